// File: rtl/bch_pkg.sv
// Shared constants and GF(16) tables for the
// serial BCH(15,7) syndrome receiver.
package bch_pkg;

  localparam int BCH_N = 15;
  localparam int BCH_K = 7;
  localparam logic [8:0] GEN_POLY = 9'h1D1;
  localparam logic [4:0] GF_PRIM = 5'h13;

  // alpha^i in polynomial basis, i = 0..14
  localparam logic [3:0] ALPHA_POW [15] = '{
    4'h1, 4'h2, 4'h4, 4'h8, 4'h3,
    4'h6, 4'hC, 4'hB, 4'h5, 4'hA,
    4'h7, 4'hE, 4'hF, 4'hD, 4'h9
  };

  // log_alpha(v); entry 0 is unused
  localparam logic [3:0] ALPHA_LOG [16] = '{
    4'd0,  4'd0,  4'd1,  4'd4,
    4'd2,  4'd8,  4'd5,  4'd10,
    4'd3,  4'd14, 4'd9,  4'd7,
    4'd6,  4'd13, 4'd11, 4'd12
  };

  typedef enum logic {
    IDLE,
    COLLECT
  } rx_state_t;

endpackage

// File: rtl/gf16_mul_alpha_pow.sv
// Multiply a GF(16) element by a fixed power
// of alpha using the log/antilog tables.
module gf16_mul_alpha_pow
  import bch_pkg::*;
#(
  parameter int EXP = 1
) (
  input  logic [3:0] s,
  output logic [3:0] p
);

  logic [3:0] idx;

  // zero stays zero; otherwise add exponents mod 15
  always_comb begin
    idx = 4'((int'(ALPHA_LOG[s]) + EXP) % BCH_N);
    p = 4'h0;
    if (s != 4'h0) p = ALPHA_POW[idx];
  end

endmodule

// File: rtl/bch_serial_rx.sv
// Serial BCH(15,7) receiver: shifts in a word
// MSB first and computes S1/S3 by Horner's rule.
module bch_serial_rx
  import bch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        bit_in,
  input  logic        bit_valid,
  input  logic        sof,
  output logic        bit_ready,
  output logic [14:0] cw_out,
  output logic [3:0]  s1_out,
  output logic [3:0]  s3_out,
  output logic        err_flag,
  output logic        cw_valid,
  input  logic        cw_ready,
  output logic        frame_abort
);

  localparam logic [3:0] CNT_LAST = 4'(BCH_N - 1);

  rx_state_t   state;
  logic [3:0]  cnt;
  logic [14:0] shift;
  logic [3:0]  s1;
  logic [3:0]  s3;

  logic [3:0]  s1a;
  logic [3:0]  s3a;
  logic [14:0] nxt_shift;
  logic [3:0]  nxt_s1;
  logic [3:0]  nxt_s3;
  logic        last;
  logic        xfer;

  gf16_mul_alpha_pow #(.EXP(1)) u_mul1 (
    .s (s1),
    .p (s1a)
  );

  gf16_mul_alpha_pow #(.EXP(3)) u_mul3 (
    .s (s3),
    .p (s3a)
  );

  // next-state datapath for one collected bit
  always_comb begin
    nxt_shift = {shift[13:0], bit_in};
    nxt_s1    = s1a ^ {3'b000, bit_in};
    nxt_s3    = s3a ^ {3'b000, bit_in};
    last      = (state == COLLECT) && (cnt == CNT_LAST);
    bit_ready = rst | ~(last & cw_valid & ~cw_ready);
    xfer      = bit_valid & bit_ready;
  end

  // frame FSM, syndrome registers and output word
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      shift       <= 15'd0;
      s1          <= 4'h0;
      s3          <= 4'h0;
      cw_out      <= 15'd0;
      s1_out      <= 4'h0;
      s3_out      <= 4'h0;
      err_flag    <= 1'b0;
      cw_valid    <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      frame_abort <= 1'b0;
      if (cw_valid && cw_ready) cw_valid <= 1'b0;
      if (xfer) begin
        if (sof) begin
          shift       <= {14'd0, bit_in};
          s1          <= {3'b000, bit_in};
          s3          <= {3'b000, bit_in};
          cnt         <= 4'd1;
          frame_abort <= (state == COLLECT);
          state       <= COLLECT;
        end else if (state == COLLECT) begin
          shift <= nxt_shift;
          s1    <= nxt_s1;
          s3    <= nxt_s3;
          if (cnt == CNT_LAST) begin
            cw_out   <= nxt_shift;
            s1_out   <= nxt_s1;
            s3_out   <= nxt_s3;
            err_flag <= |{nxt_s1, nxt_s3};
            cw_valid <= 1'b1;
            cnt      <= 4'd0;
            state    <= IDLE;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_bch_serial_rx.sv
// Bench for bch_serial_rx: vector table plus
// backpressure, abort and reset sequences.
module tb_bch_serial_rx;

  logic        clk = 1'b0;
  logic        rst;
  logic        bit_in;
  logic        bit_valid;
  logic        sof;
  logic        bit_ready;
  logic [14:0] cw_out;
  logic [3:0]  s1_out;
  logic [3:0]  s3_out;
  logic        err_flag;
  logic        cw_valid;
  logic        cw_ready;
  logic        frame_abort;

  int nvec = 0;
  int nfail = 0;
  int alog[15];

  typedef struct {
    logic [14:0] word;
    logic [3:0]  s1;
    logic [3:0]  s3;
    logic        err;
  } vec_t;

  vec_t vecs[12];

  bch_serial_rx dut (
    .clk         (clk),
    .rst         (rst),
    .bit_in      (bit_in),
    .bit_valid   (bit_valid),
    .sof         (sof),
    .bit_ready   (bit_ready),
    .cw_out      (cw_out),
    .s1_out      (s1_out),
    .s3_out      (s3_out),
    .err_flag    (err_flag),
    .cw_valid    (cw_valid),
    .cw_ready    (cw_ready),
    .frame_abort (frame_abort)
  );

  always #5 clk = ~clk;

  // r(alpha^pw) = XOR of alpha^(i*pw) over set bits
  function automatic logic [3:0] syn(
    logic [14:0] w, int pw);
    logic [3:0] s = 4'h0;
    for (int i = 0; i < 15; i++)
      if (w[i]) s ^= 4'(alog[(i * pw) % 15]);
    return s;
  endfunction

  task automatic chk(string name,
    logic [31:0] act, logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h",
        name, act, exp);
    end
  endtask

  task automatic chk_word(string name,
    logic [14:0] w);
    logic [3:0] a;
    logic [3:0] b;
    a = syn(w, 1);
    b = syn(w, 3);
    chk({name, "_valid"}, 32'(cw_valid), 1);
    chk({name, "_cw"}, 32'(cw_out), 32'(w));
    chk({name, "_s1"}, 32'(s1_out), 32'(a));
    chk({name, "_s3"}, 32'(s3_out), 32'(b));
    chk({name, "_err"}, 32'(err_flag),
      32'((a != 0) || (b != 0)));
  endtask

  task automatic send_bit(logic b, logic s);
    int n = 0;
    bit_in = b;
    sof = s;
    bit_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (bit_ready) break;
      n++;
      if (n > 50) begin
        nvec++;
        nfail++;
        $display("FAIL bit_ready_timeout: got 0 expected 1");
        break;
      end
    end
    @(posedge clk);
    #1;
    bit_valid = 1'b0;
    sof = 1'b0;
  endtask

  task automatic send_bits(logic [14:0] w,
    int first, int n);
    for (int i = first; i < first + n; i++)
      send_bit(w[14 - i], i == 0);
  endtask

  task automatic abort_case(string name,
    int nbits);
    logic [14:0] x;
    logic [14:0] y;
    x = 15'($urandom_range(0, 32767));
    y = 15'($urandom_range(0, 32767));
    send_bits(x, 0, nbits);
    send_bits(y, 0, 1);
    chk({name, "_abort"}, 32'(frame_abort), 1);
    chk({name, "_noword"}, 32'(cw_valid), 0);
    send_bits(y, 1, 1);
    chk({name, "_pulse"}, 32'(frame_abort), 0);
    send_bits(y, 2, 13);
    chk_word(name, y);
  endtask

  initial begin
    logic [14:0] wa;
    logic [14:0] wb;
    int v;

    v = 1;
    for (int i = 0; i < 15; i++) begin
      alog[i] = v;
      v = v << 1;
      if (v & 16) v ^= 'h13;
    end

    vecs[0] = '{15'h01D1, 4'h0, 4'h0, 1'b0};
    vecs[1] = '{15'h01D0, 4'h1, 4'h1, 1'b1};
    vecs[2] = '{15'h4000, 4'h9, 4'hF, 1'b1};
    for (int i = 3; i < 12; i++) begin
      vecs[i].word = 15'($urandom_range(0, 32767));
      vecs[i].s1 = syn(vecs[i].word, 1);
      vecs[i].s3 = syn(vecs[i].word, 3);
      vecs[i].err = (vecs[i].s1 != 0) ||
        (vecs[i].s3 != 0);
    end

    rst = 1'b1;
    bit_in = 1'b0;
    bit_valid = 1'b0;
    sof = 1'b0;
    cw_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_bit_ready", 32'(bit_ready), 1);
    chk("rst_valid", 32'(cw_valid), 0);
    chk("rst_cw", 32'(cw_out), 0);
    chk("rst_s1", 32'(s1_out), 0);
    chk("rst_s3", 32'(s3_out), 0);
    chk("rst_err", 32'(err_flag), 0);
    chk("rst_abort", 32'(frame_abort), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    send_bit(1'b1, 1'b0);
    chk("idle_discard", 32'(cw_valid), 0);

    for (int i = 0; i < 12; i++) begin
      send_bits(vecs[i].word, 0, 14);
      chk("vec_early", 32'(cw_valid), 0);
      send_bits(vecs[i].word, 14, 1);
      chk("vec_valid", 32'(cw_valid), 1);
      chk("vec_cw", 32'(cw_out),
        32'(vecs[i].word));
      chk("vec_s1", 32'(s1_out), 32'(vecs[i].s1));
      chk("vec_s3", 32'(s3_out), 32'(vecs[i].s3));
      chk("vec_err", 32'(err_flag),
        32'(vecs[i].err));
      chk("vec_abort", 32'(frame_abort), 0);
    end
    @(posedge clk);
    #1;
    chk("drain", 32'(cw_valid), 0);

    wa = 15'($urandom_range(0, 32767));
    wb = 15'($urandom_range(0, 32767));
    cw_ready = 1'b0;
    send_bits(wa, 0, 15);
    chk_word("bp_a", wa);
    send_bits(wb, 0, 14);
    bit_in = wb[0];
    sof = 1'b0;
    bit_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("bp_stall", 32'(bit_ready), 0);
      chk_word("bp_hold", wa);
    end
    cw_ready = 1'b1;
    #1;
    chk("bp_release", 32'(bit_ready), 1);
    chk_word("bp_first", wa);
    @(posedge clk);
    #1;
    bit_valid = 1'b0;
    chk_word("bp_second", wb);
    @(posedge clk);
    #1;
    chk("bp_empty", 32'(cw_valid), 0);

    abort_case("abort9", 9);
    abort_case("abort14", 14);
    @(posedge clk);
    #1;

    wa = 15'($urandom_range(0, 32767));
    wb = 15'($urandom_range(0, 32767));
    send_bits(wa, 0, 7);
    rst = 1'b1;
    #1;
    chk("mrst_ready", 32'(bit_ready), 1);
    @(posedge clk);
    #1;
    chk("mrst_abort", 32'(frame_abort), 0);
    chk("mrst_valid", 32'(cw_valid), 0);
    chk("mrst_cw", 32'(cw_out), 0);
    rst = 1'b0;
    send_bits(wb, 0, 1);
    chk("mrst_noabort", 32'(frame_abort), 0);
    send_bits(wb, 1, 14);
    chk_word("mrst_clean", wb);
    chk("mrst_abort2", 32'(frame_abort), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
      nvec, nfail);
    $finish;
  end

endmodule
